// File: rtl/otp_stream_arbiter.sv
// One-time-pad XOR stage shared round-robin between two message channels, fed from a pad FIFO.
// Optional pad_low flag is built only when OTP_PAD_LOW_EN is defined.
module otp_stream_arbiter #(
  parameter int DEPTH     = 16,
  parameter int LOW_WATER = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pad_valid,
  input  logic [7:0]               pad_data,
  output logic                     pad_ready,
  input  logic [1:0]               req_valid,
  input  logic [15:0]              req_message,
  output logic [1:0]               req_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_chan,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   pad_count,
  output logic                     pad_low
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          last_grant;
  logic          can_issue;
  logic          push;
  logic          pop;
  logic          gnt_chan;
  logic [7:0]    msg_byte;

  assign pad_ready = (pad_count != FULL);
  assign push      = pad_valid && pad_ready;
  assign can_issue = (pad_count != '0) && (!out_valid || out_ready);

  // Contention goes to the channel that did not win last time.
  always_comb begin
    req_ready = 2'b00;
    if (can_issue) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign pop      = |(req_valid & req_ready);
  assign gnt_chan = req_ready[1];
  assign msg_byte = gnt_chan ? req_message[15:8] : req_message[7:0];

  // NOTE: pad storage has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pad_data;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pad_count  <= '0;
      last_grant <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_chan   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   pad_count <= pad_count + CW'(1);
        2'b01:   pad_count <= pad_count - CW'(1);
        default: pad_count <= pad_count;
      endcase

      if (pop) begin
        out_data   <= mem[rd_ptr] ^ msg_byte;
        out_chan   <= gnt_chan;
        out_valid  <= 1'b1;
        last_grant <= gnt_chan;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef OTP_PAD_LOW_EN
  assign pad_low = (pad_count < CW'(LOW_WATER));
`else
  assign pad_low = 1'b0;
`endif

endmodule

// File: tb/tb_otp_stream_arbiter.sv
// Randomized and directed bench for otp_stream_arbiter: a queue-based pad/grant model predicts
// results into a scoreboard that a separate monitor drains whenever the sink accepts a byte.
module tb_otp_stream_arbiter;

  localparam int DEPTH = 16;
  localparam int LOW_WATER = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pad_valid;
  logic [7:0]  pad_data;
  logic        pad_ready;
  logic [1:0]  req_valid;
  logic [15:0] req_message;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_chan;
  logic        out_ready;
  logic [4:0]  pad_count;
  logic        pad_low;

  otp_stream_arbiter #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
    .clk(clk), .rst_n(rst_n),
    .pad_valid(pad_valid), .pad_data(pad_data), .pad_ready(pad_ready),
    .req_valid(req_valid), .req_message(req_message), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .out_ready(out_ready),
    .pad_count(pad_count), .pad_low(pad_low)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pad bytes in a queue, output register as plain variables.
  logic [7:0] pad_q [$];
  logic [8:0] exp_q [$];
  logic       m_last = 1'b1;
  logic       m_ov = 1'b0;
  logic [7:0] m_od = 8'h00;
  logic       m_oc = 1'b0;
  int         sz;
  int         g;
  logic [1:0] exp_rr;
  logic       exp_low;
  logic [7:0] b;
  logic       full_before;

  always @(negedge clk) begin
    sz = pad_q.size();
`ifdef OTP_PAD_LOW_EN
    exp_low = (sz < LOW_WATER);
`else
    exp_low = 1'b0;
`endif
    check("pad_count", pad_count, sz);
    check("pad_ready", pad_ready, sz != DEPTH);
    check("pad_low", pad_low, exp_low);
    check("out_valid", out_valid, m_ov);
    check("out_data_reg", out_data, m_od);
    check("out_chan_reg", out_chan, m_oc);

    exp_rr = 2'b00;
    if (sz != 0 && (!m_ov || out_ready)) begin
      if (req_valid == 2'b11)      exp_rr = (m_last == 1'b1) ? 2'b01 : 2'b10;
      else if (req_valid == 2'b01) exp_rr = 2'b01;
      else if (req_valid == 2'b10) exp_rr = 2'b10;
    end
    check("req_ready", req_ready, exp_rr);

    if (!rst_n) begin
      pad_q.delete();
      exp_q.delete();
      m_last = 1'b1;
      m_ov   = 1'b0;
      m_od   = 8'h00;
      m_oc   = 1'b0;
    end else begin
      full_before = (sz == DEPTH);
      if (exp_rr != 2'b00) begin
        g = exp_rr[1] ? 1 : 0;
        b = pad_q.pop_front();
        m_od = b ^ ((g == 1) ? req_message[15:8] : req_message[7:0]);
        m_oc = (g == 1);
        m_ov = 1'b1;
        m_last = (g == 1);
        exp_q.push_back({m_oc, m_od});
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (pad_valid && !full_before) pad_q.push_back(pad_data);
    end
  end

  // Scoreboard monitor: one expected entry per result the sink accepts.
  logic [8:0] e;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: actual result %0h required none at %0t", out_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", out_data, e[7:0]);
        check("sb_chan", out_chan, e[8]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [7:0] exp2 [4];

  initial begin
    rst_n = 1'b0; pad_valid = 1'b0; pad_data = 8'h00;
    req_valid = 2'b00; req_message = 16'h0000; out_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_pad_ready", pad_ready, 1'b1);
    check("rst_req_ready", req_ready, 2'b00);

    // Single channel: A5 ^ 3C = 99
    step(); pad_valid = 1'b1; pad_data = 8'hA5;
    step(); pad_valid = 1'b0; req_valid = 2'b01; req_message = 16'h003C;
    step(); req_valid = 2'b00;
    @(negedge clk);
    check("t1_data", out_data, 8'h99);
    check("t1_chan", out_chan, 1'b0);
    check("t1_count", pad_count, 0);

    // Contention after a fresh reset: ch0 first, then alternate
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pad_valid = 1'b1; pad_data = 8'(i + 1);
      step();
    end
    pad_valid = 1'b0;
    req_valid = 2'b11; req_message = 16'h2010;
    exp2[0] = 8'h11; exp2[1] = 8'h22; exp2[2] = 8'h13; exp2[3] = 8'h24;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("t2_data", out_data, exp2[i]);
      check("t2_chan", out_chan, i % 2);
      check("t2_valid", out_valid, 1'b1);
    end
    step(); req_valid = 2'b00;

    // Empty stall on ch1, then one pad FF gives ~message
    req_valid = 2'b10; req_message = 16'h5500;
    repeat (5) step();
    pad_valid = 1'b1; pad_data = 8'hFF;
    step(); pad_valid = 1'b0;
    step(); req_valid = 2'b00;
    @(negedge clk);
    check("t3_data", out_data, 8'hAA);
    check("t3_chan", out_chan, 1'b1);

    // Full FIFO: extra pushes ignored, pop with pad_valid does not push
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      pad_valid = 1'b1; pad_data = 8'(i + 1);
      step();
    end
    pad_data = 8'hEE;
    step(); step();
    @(negedge clk);
    check("t4_count_full", pad_count, DEPTH);
    check("t4_ready_full", pad_ready, 1'b0);
    step(); req_valid = 2'b01; req_message = 16'h0000;
    step(); req_valid = 2'b00; pad_valid = 1'b0;
    @(negedge clk);
    check("t4_count_pop", pad_count, DEPTH - 1);
    check("t4_data", out_data, 8'h01);

    // Back-pressure then drain + issue together
    out_ready = 1'b0; req_valid = 2'b01; req_message = 16'h0077;
    repeat (3) step();
    out_ready = 1'b1;
    step(); req_valid = 2'b00;
    @(negedge clk);
    check("t5_valid", out_valid, 1'b1);
    check("t5_data", out_data, 8'h75);
    check("t5_count", pad_count, DEPTH - 2);

    // Reset mid-stream with 5 pads stored and a held result
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pad_valid = 1'b1; pad_data = 8'($urandom);
      step();
    end
    pad_valid = 1'b0; out_ready = 1'b0; req_valid = 2'b01; req_message = 16'h00C3;
    step(); req_valid = 2'b00;
    @(negedge clk);
    check("t6_pre_count", pad_count, 5);
    check("t6_pre_valid", out_valid, 1'b1);
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("t6_count", pad_count, 0);
    check("t6_valid", out_valid, 1'b0);
`ifdef OTP_PAD_LOW_EN
    check("t6_pad_low", pad_low, 1'b1);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step();
      pad_valid   = ($urandom % 3) != 0;
      pad_data    = 8'($urandom);
      req_valid   = 2'($urandom);
      req_message = 16'($urandom);
      out_ready   = ($urandom % 4) != 0;
      rst_n       = ($urandom % 400) != 0;
    end

    step();
    rst_n = 1'b1; pad_valid = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
